// File: rtl/fpga_clkdiv.sv
// fpga_clkdiv -- multi-channel programmable clock divider with per-channel lock
// tracking. Every channel derives a registered divided clock (clk_div), a
// one-cycle period-start strobe (clk_en) and a locked flag from the single
// fabric clock fclk.
//
// Divide ratios pass through a per-channel shadow register. By default a new
// ratio takes effect only at the channel's own period boundary, so no period
// is ever truncated. Define FPGA_CLKDIV_PHASE_ALIGN_EN to make cfg_update
// restart every running channel at cnt=0 on the following edge instead. The
// channels then share a common phase reference after every update.
module fpga_clkdiv #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DIV_INIT    = 2
) (
  input  logic                    fclk,
  input  logic                    reset,
  input  logic [NUM_CH*DIV_W-1:0] div_cfg,
  input  logic                    cfg_update,
  input  logic [NUM_CH-1:0]       ch_enable,
  output logic [NUM_CH-1:0]       clk_div,
  output logic [NUM_CH-1:0]       clk_en,
  output logic [NUM_CH-1:0]       locked,
  output logic                    all_locked
);

  // The lock counter must be wide enough to hold LOCK_CYCLES itself.
  localparam int LOCK_W = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX   = LOCK_W'(LOCK_CYCLES);
  localparam logic [DIV_W-1:0]  DIV_INIT_V = DIV_W'(DIV_INIT);

`ifdef FPGA_CLKDIV_PHASE_ALIGN_EN
  localparam bit PHASE_ALIGN = 1'b1;
`else
  localparam bit PHASE_ALIGN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_RELOCK
  } ch_state_t;

  // Ratios 0 and 1 cannot form a two-phase clock, so they run as divide-by-2.
  function automatic logic [DIV_W-1:0] eff_ratio(input logic [DIV_W-1:0] r);
    return (r < DIV_W'(2)) ? DIV_W'(2) : r;
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

    // Architectural state of this channel.
    ch_state_t         state;
    logic [DIV_W-1:0]  cnt;
    logic [LOCK_W-1:0] lock_cnt;
    logic [DIV_W-1:0]  cur_ratio;
    logic [DIV_W-1:0]  shadow_ratio;
    logic              pending;
    logic              div_q;
    logic              en_q;
    logic              lock_q;

    // Next-state values.
    ch_state_t         state_d;
    logic [DIV_W-1:0]  cnt_d;
    logic [LOCK_W-1:0] lock_d;
    logic [DIV_W-1:0]  cur_d;
    logic [DIV_W-1:0]  shadow_d;
    logic              pending_d;
    logic              div_d;
    logic              en_d;
    logic              lock_flag_d;

    // Helper terms.
    logic [DIV_W-1:0]  cfg_slice;
    logic [DIV_W-1:0]  cur_n;
    logic [DIV_W-1:0]  new_ratio;
    logic              have_new;
    logic              at_boundary;
    logic              restart;
    logic              apply_new;
    logic              active_d;
    logic [DIV_W:0]    high_len;

    // Compute this channel's next state, counters and registered outputs.
    always_comb begin
      // NOTE: every variable gets a default first so that no path through the
      // case statement leaves one unassigned, which would infer a latch.
      cfg_slice   = div_cfg[i*DIV_W +: DIV_W];
      cur_n       = eff_ratio(cur_ratio);
      new_ratio   = cfg_update ? cfg_slice : shadow_ratio;
      have_new    = cfg_update | pending;
      at_boundary = (cnt == cur_n - DIV_W'(1));
      restart     = at_boundary | (PHASE_ALIGN & cfg_update);
      apply_new   = 1'b0;

      state_d     = state;
      cnt_d       = cnt;
      lock_d      = lock_cnt;
      cur_d       = cur_ratio;
      shadow_d    = cfg_update ? cfg_slice : shadow_ratio;
      pending_d   = pending | cfg_update;

      case (state)
        ST_IDLE: begin
          // While the channel is stopped, a new ratio takes effect at once.
          cnt_d  = '0;
          lock_d = '0;
          if (have_new) begin
            cur_d     = new_ratio;
            pending_d = 1'b0;
          end
          if (ch_enable[i]) begin
            state_d = ST_RUN;
          end
        end

        ST_RUN, ST_RELOCK: begin
          if (!ch_enable[i]) begin
            // A disable stops the channel immediately. Any queued ratio is
            // applied so that the next run starts with the latest setting.
            state_d = ST_IDLE;
            cnt_d   = '0;
            lock_d  = '0;
            if (have_new) begin
              cur_d     = new_ratio;
              pending_d = 1'b0;
            end
          end else begin
            cnt_d     = restart ? '0 : cnt + DIV_W'(1);
            lock_d    = (lock_cnt >= LOCK_MAX) ? lock_cnt : lock_cnt + LOCK_W'(1);
            apply_new = restart & have_new;
            if (apply_new) begin
              cur_d     = new_ratio;
              pending_d = 1'b0;
              if (eff_ratio(new_ratio) != cur_n) begin
                lock_d  = '0;
                state_d = ST_RELOCK;
              end
            end
            if (state_d == ST_RELOCK && lock_d >= LOCK_MAX) begin
              state_d = ST_RUN;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          lock_d  = '0;
        end
      endcase

      // Derive the outputs from the next state so that they are registered
      // alongside it and line up with cnt cycle for cycle. The high phase
      // uses the ratio of the period that is about to run.
      active_d    = (state_d != ST_IDLE);
      high_len    = ({1'b0, eff_ratio(cur_d)} + (DIV_W + 1)'(1)) >> 1;
      en_d        = active_d & (cnt_d == '0);
      div_d       = active_d & ({1'b0, cnt_d} < high_len);
      lock_flag_d = active_d & (lock_d >= LOCK_MAX);
    end

    // Channel registers. The synchronous reset overrides enable and update.
    always_ff @(posedge fclk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples values from before this clock edge.
      if (reset) begin
        state        <= ST_IDLE;
        cnt          <= '0;
        lock_cnt     <= '0;
        cur_ratio    <= DIV_INIT_V;
        shadow_ratio <= DIV_INIT_V;
        pending      <= 1'b0;
        div_q        <= 1'b0;
        en_q         <= 1'b0;
        lock_q       <= 1'b0;
      end else begin
        state        <= state_d;
        cnt          <= cnt_d;
        lock_cnt     <= lock_d;
        cur_ratio    <= cur_d;
        shadow_ratio <= shadow_d;
        pending      <= pending_d;
        div_q        <= div_d;
        en_q         <= en_d;
        lock_q       <= lock_flag_d;
      end
    end

    assign clk_div[i] = div_q;
    assign clk_en[i]  = en_q;
    assign locked[i]  = lock_q;
  end

  // all_locked reports on the enabled channels only. It is low when no
  // channel is enabled.
  assign all_locked = (|ch_enable) & (&(locked | ~ch_enable));

endmodule

// File: tb/tb_fpga_clkdiv.sv
// Testbench for fpga_clkdiv. A behavioural model tracks each channel as a
// running flag, the position within the current period, the period length
// and the number of cycles since the last (re)start of locking. The outputs
// are compared against this model on every cycle. Directed sequences also
// confirm the period, duty and lock timing against fixed expected values.
// The build follows FPGA_CLKDIV_PHASE_ALIGN_EN in the same way as the design.
module tb_fpga_clkdiv;

  localparam int NUM_CH      = 4;
  localparam int DIV_W       = 8;
  localparam int LOCK_CYCLES = 16;
  localparam int DIV_INIT    = 2;

`ifdef FPGA_CLKDIV_PHASE_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic                    fclk;
  logic                    reset;
  logic [NUM_CH*DIV_W-1:0] div_cfg;
  logic                    cfg_update;
  logic [NUM_CH-1:0]       ch_enable;
  logic [NUM_CH-1:0]       clk_div;
  logic [NUM_CH-1:0]       clk_en;
  logic [NUM_CH-1:0]       locked;
  logic                    all_locked;

  fpga_clkdiv #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .LOCK_CYCLES (LOCK_CYCLES),
    .DIV_INIT    (DIV_INIT)
  ) dut (
    .fclk       (fclk),
    .reset      (reset),
    .div_cfg    (div_cfg),
    .cfg_update (cfg_update),
    .ch_enable  (ch_enable),
    .clk_div    (clk_div),
    .clk_en     (clk_en),
    .locked     (locked),
    .all_locked (all_locked)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model state, one entry per channel.
  bit m_run     [NUM_CH];
  int m_phase   [NUM_CH];
  int m_len     [NUM_CH];
  bit m_pend    [NUM_CH];
  int m_pend_len[NUM_CH];
  int m_age     [NUM_CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int eff(input int r);
    return (r < 2) ? 2 : r;
  endfunction

  // Advance the model by one fclk edge, using the inputs currently driven.
  function automatic void model_step();
    for (int c = 0; c < NUM_CH; c++) begin
      int req;
      bit restart;
      req = eff(int'(div_cfg[c*DIV_W +: DIV_W]));
      if (reset) begin
        m_run[c]      = 1'b0;
        m_phase[c]    = 0;
        m_age[c]      = 0;
        m_len[c]      = eff(DIV_INIT);
        m_pend[c]     = 1'b0;
        m_pend_len[c] = eff(DIV_INIT);
        continue;
      end
      if (cfg_update) begin
        m_pend[c]     = 1'b1;
        m_pend_len[c] = req;
      end
      if (!m_run[c]) begin
        if (m_pend[c]) begin
          m_len[c]  = m_pend_len[c];
          m_pend[c] = 1'b0;
        end
        if (ch_enable[c]) begin
          m_run[c]   = 1'b1;
          m_phase[c] = 0;
          m_age[c]   = 0;
        end
      end else if (!ch_enable[c]) begin
        if (m_pend[c]) m_len[c] = m_pend_len[c];
        m_pend[c]  = 1'b0;
        m_run[c]   = 1'b0;
        m_phase[c] = 0;
        m_age[c]   = 0;
      end else begin
        restart = (m_phase[c] == m_len[c] - 1) || (ALIGN && cfg_update);
        m_age[c]++;
        if (restart) begin
          m_phase[c] = 0;
          if (m_pend[c]) begin
            if (m_pend_len[c] != m_len[c]) m_age[c] = 0;
            m_len[c]  = m_pend_len[c];
            m_pend[c] = 1'b0;
          end
        end else begin
          m_phase[c]++;
        end
      end
    end
  endfunction

  task automatic compare_all();
    logic [NUM_CH-1:0] e_div, e_en, e_lock;
    logic e_all;
    for (int c = 0; c < NUM_CH; c++) begin
      e_en[c]   = m_run[c] && (m_phase[c] == 0);
      e_div[c]  = m_run[c] && (m_phase[c] < (m_len[c] + 1) / 2);
      e_lock[c] = m_run[c] && (m_age[c] >= LOCK_CYCLES);
    end
    e_all = (ch_enable != '0) && ((e_lock | ~ch_enable) == '1);
    check("clk_div", 32'(clk_div), 32'(e_div));
    check("clk_en", 32'(clk_en), 32'(e_en));
    check("locked", 32'(locked), 32'(e_lock));
    check("all_locked", 32'(all_locked), 32'(e_all));
  endtask

  // One fclk cycle: edge, model update, sample 1 ns later, then return at the
  // falling edge, where the caller drives the next inputs.
  task automatic tick();
    @(posedge fclk);
    model_step();
    #1;
    cyc++;
    compare_all();
    @(negedge fclk);
  endtask

  // Run until clk_en[0] is seen. The number of cycles is bounded.
  task automatic sync_ce0(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (clk_en[0] !== 1'b1 && n < 20);
    check(tag, 32'(clk_en[0]), 32'd1);
  endtask

  task automatic set_ratio(input int ch, input int val);
    div_cfg[ch*DIV_W +: DIV_W] = DIV_W'(val);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_cnt, hi_cnt, first_en, second_en, fall_k, rise_k, first_lock, first_all;
    int ratios[4];
    int exp_en[4];
    int exp_hi[4];
    ratios = '{5, 0, 1, 2};
    exp_en = '{4, 10, 10, 10};
    exp_hi = '{12, 10, 10, 10};

    reset      = 1'b1;
    cfg_update = 1'b0;
    div_cfg    = '0;
    ch_enable  = '0;

    // Reset, then ratio 4 on ch0: period, duty and lock timing.
    repeat (3) tick();
    check("reset_outs", 32'({clk_div, clk_en, locked, all_locked}), 32'd0);
    reset = 1'b0;
    set_ratio(0, 4);
    cfg_update = 1'b1;
    tick();
    cfg_update   = 1'b0;
    ch_enable[0] = 1'b1;
    en_cnt = 0; hi_cnt = 0; first_en = -1; first_lock = -1; first_all = -1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (clk_en[0]) en_cnt++;
      if (clk_div[0]) hi_cnt++;
      if (clk_en[0] && first_en < 0) first_en = k;
      if (locked[0] && first_lock < 0) first_lock = k;
      if (all_locked && first_all < 0) first_all = k;
    end
    check("r4_first_en", 32'(first_en), 32'd0);
    check("r4_en_count", 32'(en_cnt), 32'd10);
    check("r4_high_count", 32'(hi_cnt), 32'd20);
    check("r4_lock_at", 32'(first_lock), 32'd16);
    check("r4_all_locked_at", 32'(first_all), 32'd16);

    // Odd ratio and the degenerate ratios 0 and 1.
    for (int r = 0; r < 4; r++) begin
      ch_enable[0] = 1'b0;
      tick();
      set_ratio(0, ratios[r]);
      cfg_update = 1'b1;
      tick();
      cfg_update   = 1'b0;
      ch_enable[0] = 1'b1;
      en_cnt = 0; hi_cnt = 0;
      for (int k = 0; k < 20; k++) begin
        tick();
        if (clk_en[0]) en_cnt++;
        if (clk_div[0]) hi_cnt++;
      end
      check($sformatf("ratio%0d_en_count", ratios[r]), 32'(en_cnt), 32'(exp_en[r]));
      check($sformatf("ratio%0d_high_count", ratios[r]), 32'(hi_cnt), 32'(exp_hi[r]));
    end

    // Change 4 -> 6 while cnt=1.
    ch_enable[0] = 1'b0;
    tick();
    set_ratio(0, 4);
    cfg_update = 1'b1;
    tick();
    cfg_update   = 1'b0;
    ch_enable[0] = 1'b1;
    repeat (20) tick();
    sync_ce0("sync_c");
    tick();
    set_ratio(0, 6);
    cfg_update = 1'b1;
    first_en = -1; second_en = -1; fall_k = -1; rise_k = -1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (k == 0) cfg_update = 1'b0;
      if (clk_en[0]) begin
        if (first_en < 0) first_en = k;
        else if (second_en < 0) second_en = k;
      end
      if (!locked[0] && fall_k < 0) fall_k = k;
      if (locked[0] && fall_k >= 0 && rise_k < 0) rise_k = k;
    end
    check("upd_first_en", 32'(first_en), ALIGN ? 32'd0 : 32'd2);
    check("upd_new_period", 32'(second_en - first_en), 32'd6);
    check("upd_lock_drop", 32'(fall_k), 32'(first_en));
    check("upd_relock", 32'(rise_k - fall_k), 32'd16);

    // Two updates in one period: 6 then 3. Only the last ratio takes effect.
    sync_ce0("sync_d");
    tick();
    set_ratio(0, 6);
    cfg_update = 1'b1;
    tick();
    set_ratio(0, 3);
    tick();
    cfg_update = 1'b0;
    first_en = -1; second_en = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (clk_en[0]) begin
        if (first_en < 0) first_en = k;
        else if (second_en < 0) second_en = k;
      end
    end
    check("latest_first_en", 32'(first_en), 32'd2);
    check("latest_period", 32'(second_en - first_en), 32'd3);

    // Disable at cnt=2, re-enable, then reset mid-period.
    sync_ce0("sync_e");
    tick();
    tick();
    ch_enable[0] = 1'b0;
    tick();
    check("disable_outs", 32'({clk_div[0], clk_en[0], locked[0]}), 32'd0);
    ch_enable[0] = 1'b1;
    tick();
    check("reenable_en", 32'({clk_div[0], clk_en[0]}), 32'd3);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("midreset_outs", 32'({clk_div, clk_en, locked, all_locked}), 32'd0);
    reset = 1'b0;
    tick();
    check("post_reset_en", 32'(clk_en[0]), 32'd1);

    // ch0 at 4 and ch1 at 6, started out of phase, then a common update.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_ratio(0, 4);
    set_ratio(1, 6);
    cfg_update = 1'b1;
    tick();
    cfg_update   = 1'b0;
    ch_enable[0] = 1'b1;
    tick();
    ch_enable[1] = 1'b1;
    repeat (10) tick();
    sync_ce0("sync_f");
    tick();
    set_ratio(0, 5);
    set_ratio(1, 3);
    cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
`ifdef FPGA_CLKDIV_PHASE_ALIGN_EN
    check("align_both_en", 32'(clk_en[1:0]), 32'd3);
`else
    check("own_boundary_ch0", 32'(clk_en[0]), 32'd0);
`endif
    repeat (30) tick();

    // Randomized traffic against the model.
    ch_enable = '1;
    for (int t = 0; t < 800; t++) begin
      int idx;
      reset      = ($urandom_range(0, 199) == 0);
      cfg_update = ($urandom_range(0, 7) == 0);
      if (cfg_update) begin
        for (int c = 0; c < NUM_CH; c++) set_ratio(c, $urandom_range(0, 9));
      end
      if ($urandom_range(0, 31) == 0) begin
        idx = $urandom_range(0, NUM_CH - 1);
        ch_enable[idx] = ~ch_enable[idx];
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
